// File: rtl/one_bc_if.sv
// I/O bundle for the 1-bit computer: the input bits going in and the output
// register bits coming out.
interface one_bc_if;
  logic [7:0] ins_i;
  logic [7:0] outs_o;

  // Driver side: supplies the input bits and observes the outputs.
  modport master (output ins_i, input outs_o);
  // Core side: consumes the input bits and drives the output register.
  modport slave (input ins_i, output outs_o);
endinterface

// File: rtl/one_bc.sv
// Minimal 1-bit computer: a 1-bit result register, a 5-bit program counter and
// a fixed 32-word combinational program ROM, one instruction per clock. The
// built-in program makes every output bit sticky once its input is seen high.
module one_bc (
  input  logic     clk_i,
  input  logic     arst_i,
  one_bc_if.slave  io
);

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0,
    OP_LDI  = 4'h1,
    OP_LDO  = 4'h2,
    OP_ANDI = 4'h3,
    OP_ORI  = 4'h4,
    OP_ORO  = 4'h5,
    OP_STO  = 4'h6,
    OP_STOC = 4'h7,
    OP_SET  = 4'h8,
    OP_CLR  = 4'h9,
    OP_JMP  = 4'hA
  } op_e;

  logic [4:0] pc;
  logic       rr;
  logic [7:0] outs;
  logic [7:0] lat;

  logic [8:0] instr;
  op_e        op;
  logic [4:0] arg;
  logic [2:0] idx;
  logic [7:0] in_eff;
  logic [7:0] lat_next;

  assign io.outs_o = outs;

  // Program ROM: for each bit i, LDI i / ORO i / STO i, then loop back to 0.
  always_comb begin
    // NOTE: every signal written in always_comb gets a default first, so no
    // path through the case can leave it unassigned and infer a latch.
    instr = {OP_NOP, 5'd0};
    case (pc)
      5'd0:  instr = {OP_LDI, 5'd0};
      5'd1:  instr = {OP_ORO, 5'd0};
      5'd2:  instr = {OP_STO, 5'd0};
      5'd3:  instr = {OP_LDI, 5'd1};
      5'd4:  instr = {OP_ORO, 5'd1};
      5'd5:  instr = {OP_STO, 5'd1};
      5'd6:  instr = {OP_LDI, 5'd2};
      5'd7:  instr = {OP_ORO, 5'd2};
      5'd8:  instr = {OP_STO, 5'd2};
      5'd9:  instr = {OP_LDI, 5'd3};
      5'd10: instr = {OP_ORO, 5'd3};
      5'd11: instr = {OP_STO, 5'd3};
      5'd12: instr = {OP_LDI, 5'd4};
      5'd13: instr = {OP_ORO, 5'd4};
      5'd14: instr = {OP_STO, 5'd4};
      5'd15: instr = {OP_LDI, 5'd5};
      5'd16: instr = {OP_ORO, 5'd5};
      5'd17: instr = {OP_STO, 5'd5};
      5'd18: instr = {OP_LDI, 5'd6};
      5'd19: instr = {OP_ORO, 5'd6};
      5'd20: instr = {OP_STO, 5'd6};
      5'd21: instr = {OP_LDI, 5'd7};
      5'd22: instr = {OP_ORO, 5'd7};
      5'd23: instr = {OP_STO, 5'd7};
      5'd24: instr = {OP_JMP, 5'd0};
      default: instr = {OP_NOP, 5'd0};
    endcase
  end

  // Decode the current word; opcodes B-F fall through to NOP in the executor.
  always_comb begin
    op     = op_e'(instr[8:5]);
    arg    = instr[4:0];
    idx    = arg[2:0];
    in_eff = lat | io.ins_i;
  end

  // Capture latches accumulate pulses; LDI consumes its bit, but a pulse
  // arriving on that same edge is kept for the next read.
  always_comb begin
    lat_next = lat | io.ins_i;
    if (op == OP_LDI) lat_next[idx] = io.ins_i[idx];
  end

  // Execute one instruction per clock and advance the program counter.
  always_ff @(posedge clk_i) begin
    // NOTE: all sequential state uses non-blocking assignments so every
    // instruction sees the register values from before this edge.
    if (arst_i) begin
      pc   <= 5'd0;
      rr   <= 1'b0;
      outs <= 8'h00;
      lat  <= 8'h00;
    end else begin
      pc  <= pc + 5'd1;
      lat <= lat_next;
      case (op)
        OP_LDI:  rr <= in_eff[idx];
        OP_LDO:  rr <= outs[idx];
        OP_ANDI: rr <= rr & in_eff[idx];
        OP_ORI:  rr <= rr | in_eff[idx];
        OP_ORO:  rr <= rr | outs[idx];
        OP_STO:  outs[idx] <= rr;
        OP_STOC: outs[idx] <= ~rr;
        OP_SET:  rr <= 1'b1;
        OP_CLR:  rr <= 1'b0;
        OP_JMP:  pc <= arg;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_one_bc.sv
// Self-checking bench for one_bc. The reference model works purely from the
// observable contract: an output bit may only be set after its input was seen
// high since the last reset, must be set no later than 28 clocks after that
// first pulse, and never clears until reset.
module tb_one_bc;

  logic clk_i = 1'b0;
  logic arst_i;

  one_bc_if bus ();

  one_bc dut (
    .clk_i  (clk_i),
    .arst_i (arst_i),
    .io     (bus)
  );

  always #5 clk_i = ~clk_i;

  int         checks;
  int         errors;
  int         edge_n;
  logic [7:0] seen;
  logic [7:0] prev;
  int         first_edge [8];

  // Count one comparison and report it if the observed value is wrong.
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, act, exp, edge_n);
    end
  endtask

  // Advance one clock with the currently driven inputs, update the model and
  // compare the outputs against the contract, sampled 1 ns after the edge.
  task automatic tick();
    logic       r;
    logic [7:0] v;
    logic [7:0] due;
    r = arst_i;
    v = bus.ins_i;
    @(posedge clk_i);
    #1;
    edge_n++;
    if (r) begin
      seen = 8'h00;
      prev = 8'h00;
      check("reset_outs", bus.outs_o, 8'h00);
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (v[i] && !seen[i]) begin
          seen[i]       = 1'b1;
          first_edge[i] = edge_n;
        end
      end
      due = 8'h00;
      for (int i = 0; i < 8; i++)
        if (seen[i] && (edge_n - first_edge[i] >= 28)) due[i] = 1'b1;
      check("spurious_bit", bus.outs_o & ~seen, 8'h00);
      check("late_bit", due & ~bus.outs_o, 8'h00);
      check("cleared_bit", prev & ~bus.outs_o, 8'h00);
      prev = bus.outs_o;
    end
  endtask

  task automatic drive(input logic rst, input logic [7:0] ins, input int n);
    arst_i    = rst;
    bus.ins_i = ins;
    for (int k = 0; k < n; k++) tick();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    edge_n = 0;
    seen   = 8'h00;
    prev   = 8'h00;
    for (int i = 0; i < 8; i++) first_edge[i] = 0;
    arst_i    = 1'b1;
    bus.ins_i = 8'h00;

    // Reset for 2 clocks with noise on the inputs, which must be ignored.
    drive(1'b1, 8'($urandom), 2);
    drive(1'b0, 8'h00, 60);
    check("idle_outs", bus.outs_o, 8'h00);

    // Bit 0 held for 2 clocks.
    drive(1'b0, 8'h01, 2);
    drive(1'b0, 8'h00, 30);
    check("bit0_outs", bus.outs_o, 8'h01);

    // Walk one-hot through the remaining bits.
    for (int i = 1; i < 8; i++) drive(1'b0, 8'(1 << i), 2);
    drive(1'b0, 8'h00, 30);
    check("walk_outs", bus.outs_o, 8'hFF);
    drive(1'b0, 8'h00, 25);
    check("walk_hold", bus.outs_o, 8'hFF);

    // One-clock reset mid-loop clears everything.
    drive(1'b0, 8'h00, 7);
    drive(1'b1, 8'h00, 1);
    check("midloop_reset", bus.outs_o, 8'h00);

    // Single-clock pulse on bit 4 at a random phase; the latch must hold it.
    drive(1'b0, 8'h00, 1 + int'($urandom_range(0, 24)));
    drive(1'b0, 8'h10, 1);
    drive(1'b0, 8'h00, 30);
    check("bit4_pulse", bus.outs_o, 8'h10);

    // Multi-bit single-clock pulse.
    drive(1'b1, 8'h00, 1);
    drive(1'b0, 8'h00, 1 + int'($urandom_range(0, 24)));
    drive(1'b0, 8'hA5, 1);
    drive(1'b0, 8'h00, 30);
    check("a5_pulse", bus.outs_o, 8'hA5);

    // Pulses immediately followed by reset must leave no stale latched input.
    for (int t = 0; t < 4; t++) begin
      drive(1'b0, 8'h00, 1 + int'($urandom_range(0, 24)));
      drive(1'b0, 8'($urandom), 1);
      drive(1'b1, 8'($urandom), 1);
      drive(1'b0, 8'h00, 60);
      check("no_stale", bus.outs_o, 8'h00);
    end

    // Randomised sparse pulses with occasional resets.
    for (int t = 0; t < 8; t++) begin
      drive(1'b1, 8'h00, 1);
      for (int c = 0; c < 150; c++) begin
        if ($urandom_range(0, 99) == 0)
          drive(1'b1, 8'($urandom), 1);
        else if ($urandom_range(0, 7) == 0)
          drive(1'b0, 8'($urandom) & 8'($urandom), 1);
        else
          drive(1'b0, 8'h00, 1);
      end
      drive(1'b0, 8'h00, 30);
      check("random_final", bus.outs_o, seen);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
